// File: rtl/multi_board_timer_pkg.sv
// ============================================================================
// Module      : multi_board_timer_pkg
// Description : Shared types and default sizes for the multi-channel timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_board_timer_pkg;

  localparam int unsigned C_DEF_NUM_CH = 4;
  localparam int unsigned C_DEF_WIDTH  = 28;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage : multi_board_timer_pkg

`default_nettype wire

// File: rtl/multi_board_timer_channel.sv
// ============================================================================
// Module      : board_timer_channel
// Description : One count-down channel: FSM, counter, reload value and mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_timer_channel
  import multi_board_timer_pkg::*;
#(
  parameter int unsigned WIDTH = C_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadval_i,
  input  logic             periodic_i,
  input  logic             pause_i,
  output logic             trigger_o,
  output logic             busy_o
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             trig_q, trig_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CH_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      trig_q   <= trig_d;
    end
  end

  // A load outranks expiry and pause; a zero load value cancels the channel.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    trig_d   = 1'b0;
    if (load_i) begin
      if (loadval_i != '0) begin
        state_d  = CH_RUN;
        count_d  = loadval_i;
        reload_d = loadval_i;
        mode_d   = periodic_i;
      end else begin
        state_d = CH_IDLE;
        count_d = '0;
      end
    end else if (state_q == CH_RUN && !pause_i && tick_i) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        trig_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          state_d = CH_IDLE;
          count_d = '0;
        end
      end
    end
  end

  always_comb begin
    trigger_o = trig_q;
    busy_o    = (state_q == CH_RUN);
  end

endmodule : board_timer_channel

`default_nettype wire

// File: rtl/multi_board_timer.sv
// ============================================================================
// Module      : multi_board_timer
// Description : Shared prescaler driving NUM_CH independent count-down timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_board_timer
  import multi_board_timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = C_DEF_NUM_CH,
  parameter int unsigned WIDTH    = C_DEF_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] loadval,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       pause,
  output logic [NUM_CH-1:0]       time_trigger,
  output logic [NUM_CH-1:0]       busy
);

  logic w_tick;

  generate
    if (PRESCALE <= 1) begin : g_no_prescale
      assign w_tick = 1'b1;
    end else begin : g_prescale
      localparam int unsigned PW = $clog2(PRESCALE);

      logic [PW-1:0] pc_q, pc_d;

      // Free-running; loads never restart it, so channels stay phase-aligned.
      always_ff @(posedge clk) begin
        if (rst) begin
          pc_q <= '0;
        end else begin
          pc_q <= pc_d;
        end
      end

      always_comb begin
        pc_d = w_tick ? '0 : pc_q + PW'(1);
      end

      assign w_tick = (pc_q == PW'(PRESCALE - 1));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      board_timer_channel #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (w_tick),
        .load_i    (load[gi]),
        .loadval_i (loadval[gi*WIDTH +: WIDTH]),
        .periodic_i(periodic[gi]),
        .pause_i   (pause[gi]),
        .trigger_o (time_trigger[gi]),
        .busy_o    (busy[gi])
      );
    end
  endgenerate

endmodule : multi_board_timer

`default_nettype wire

// File: tb/tb_multi_board_timer.sv
// ============================================================================
// Module      : tb_multi_board_timer
// Description : Self-checking bench for multi_board_timer (PRESCALE 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_board_timer;

  localparam int NCH = 4;
  localparam int W   = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst      = 1'b1;
  logic [NCH-1:0]   load     = '0;
  logic [NCH-1:0]   periodic = '0;
  logic [NCH-1:0]   pause    = '0;
  logic [NCH*W-1:0] loadval  = '0;
  logic [NCH-1:0]   trig_p1, busy_p1, trig_p4, busy_p4;

  multi_board_timer #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .loadval(loadval), .periodic(periodic),
    .pause(pause), .time_trigger(trig_p1), .busy(busy_p1)
  );

  multi_board_timer #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .loadval(loadval), .periodic(periodic),
    .pause(pause), .time_trigger(trig_p4), .busy(busy_p4)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  bit chk_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ticks remaining until expiry per channel, for both prescales.
  function automatic int ps(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  bit     m_act [2][NCH];
  bit     m_mode[2][NCH];
  bit     m_trig[2][NCH];
  longint m_rem [2][NCH];
  longint m_per [2][NCH];
  int     m_pc  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_act[d][c] = 0; m_mode[d][c] = 0; m_trig[d][c] = 0;
        m_rem[d][c] = 0; m_per[d][c] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit tk;
      tk = (m_pc[d] == ps(d) - 1);
      m_pc[d] = rst ? 0 : (m_pc[d] + 1) % ps(d);
      for (int c = 0; c < NCH; c++) begin
        longint v;
        v = longint'(loadval[c*W +: W]);
        m_trig[d][c] = 0;
        if (rst) begin
          m_act[d][c] = 0; m_mode[d][c] = 0; m_rem[d][c] = 0; m_per[d][c] = 0;
        end else if (load[c]) begin
          if (v != 0) begin
            m_act[d][c] = 1; m_rem[d][c] = v; m_per[d][c] = v; m_mode[d][c] = periodic[c];
          end else begin
            m_act[d][c] = 0; m_rem[d][c] = 0;
          end
        end else if (m_act[d][c] && !pause[c] && tk) begin
          m_rem[d][c] = m_rem[d][c] - 1;
          if (m_rem[d][c] == 0) begin
            m_trig[d][c] = 1;
            if (m_mode[d][c]) m_rem[d][c] = m_per[d][c];
            else m_act[d][c] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH; c++) begin
          check($sformatf("model trig p%0d ch%0d", ps(d), c),
                64'((d == 0) ? trig_p1[c] : trig_p4[c]), 64'(m_trig[d][c]));
          check($sformatf("model busy p%0d ch%0d", ps(d), c),
                64'((d == 0) ? busy_p1[c] : busy_p4[c]), 64'(m_act[d][c]));
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; load = '0; pause = '0; periodic = '0; loadval = '0;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset trig", 64'({trig_p4, trig_p1}), 64'(0));
    check("reset busy", 64'({busy_p4, busy_p1}), 64'(0));
  endtask

  task automatic set_load(input int c, input logic [W-1:0] v, input logic per);
    load[c] = 1'b1;
    loadval[c*W +: W] = v;
    periodic[c] = per;
  endtask

  int first_k, second_k;
  logic [W-1:0] rv;

  initial begin
    step();
    do_reset();

    // One-shot 5 on ch0
    set_load(0, 5, 1'b0);
    step();
    load = '0;
    for (int k = 0; k <= 7; k++) begin
      check("A trig0", 64'(trig_p1[0]), 64'(k == 5));
      check("A busy0", 64'(busy_p1[0]), 64'(k < 5));
      step();
    end

    // Periodic 3 on ch1, cancelled by a zero load
    do_reset();
    set_load(1, 3, 1'b1);
    step();
    load = '0;
    for (int k = 0; k <= 10; k++) begin
      check("B trig1", 64'(trig_p1[1]), 64'(k == 3 || k == 6));
      check("B busy1", 64'(busy_p1[1]), 64'(k < 7));
      if (k == 6) set_load(1, 0, 1'b0);
      if (k == 7) load = '0;
      step();
    end

    // Pause on ch2 delays expiry; ch0 unaffected
    do_reset();
    set_load(2, 4, 1'b0);
    set_load(0, 4, 1'b0);
    step();
    load = '0;
    for (int k = 0; k <= 10; k++) begin
      check("C trig2", 64'(trig_p1[2]), 64'(k == 8));
      check("C busy2", 64'(busy_p1[2]), 64'(k < 8));
      check("C trig0", 64'(trig_p1[0]), 64'(k == 4));
      if (k == 1) pause[2] = 1'b1;
      if (k == 5) pause[2] = 1'b0;
      step();
    end

    // Reload on the expiry edge suppresses that trigger
    do_reset();
    set_load(3, 3, 1'b0);
    step();
    load = '0;
    for (int k = 0; k <= 15; k++) begin
      check("D trig3", 64'(trig_p1[3]), 64'(k == 13));
      check("D busy3", 64'(busy_p1[3]), 64'(k < 13));
      if (k == 2) set_load(3, 10, 1'b0);
      if (k == 3) load = '0;
      step();
    end

    // Prescale 4: first expiry window and exact period
    do_reset();
    set_load(0, 2, 1'b1);
    step();
    load = '0;
    first_k = -1; second_k = -1;
    for (int k = 0; k <= 24; k++) begin
      if (trig_p4[0] === 1'b1) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
      step();
    end
    check("E first in 5..8", 64'(first_k >= 5 && first_k <= 8), 64'(1));
    check("E period 8", 64'(second_k - first_k), 64'(8));

    // Reset in the middle of running channels
    do_reset();
    for (int c = 0; c < NCH; c++) set_load(c, 6, 1'b1);
    step();
    load = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("F trig after rst", 64'({trig_p4, trig_p1}), 64'(0));
    check("F busy after rst", 64'({busy_p4, busy_p1}), 64'(0));
    for (int k = 0; k < 15; k++) begin
      step();
      check("F quiet trig", 64'({trig_p4, trig_p1}), 64'(0));
    end

    // Long all-ones count must stay busy with no trigger
    set_load(1, {W{1'b1}}, 1'b0);
    step();
    load = '0;
    repeat (10) step();
    check("G ones busy", 64'(busy_p1[1]), 64'(1));

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        load[c] = ($urandom_range(0, 9) == 0);
        if (load[c]) begin
          case ($urandom_range(0, 15))
            0:       rv = '0;
            1:       rv = {W{1'b1}};
            default: rv = W'($urandom_range(1, 12));
          endcase
          loadval[c*W +: W] = rv;
          periodic[c] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) pause[c] = ~pause[c];
      end
    end
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_multi_board_timer

`default_nettype wire
